// File: rtl/seg7_pkg.sv
// Shared glyph constants and the code-to-glyph mapping for the
// 7-segment scan controller. Glyphs are active low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Codes above 9 show a dash unless hex letters are enabled.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hexMode);
    logic [6:0] glyph;
    glyph = SEG_DASH;
    case (code)
      4'h0: glyph = SEG_0;
      4'h1: glyph = SEG_1;
      4'h2: glyph = SEG_2;
      4'h3: glyph = SEG_3;
      4'h4: glyph = SEG_4;
      4'h5: glyph = SEG_5;
      4'h6: glyph = SEG_6;
      4'h7: glyph = SEG_7;
      4'h8: glyph = SEG_8;
      4'h9: glyph = SEG_9;
      4'hA: glyph = hexMode ? SEG_A : SEG_DASH;
      4'hB: glyph = hexMode ? SEG_B : SEG_DASH;
      4'hC: glyph = hexMode ? SEG_C : SEG_DASH;
      4'hD: glyph = hexMode ? SEG_D : SEG_DASH;
      4'hE: glyph = hexMode ? SEG_E : SEG_DASH;
      4'hF: glyph = hexMode ? SEG_F : SEG_DASH;
      default: glyph = SEG_DASH;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph decoder used on the currently scanned digit.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0] code_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = seg7_glyph(code_i, HEX_MODE);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display:
// digit scanning, glyph decode, decimal points, leading-zero blanking,
// per-digit blinking and PWM dimming. All outputs are registered.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 4096,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FC_W-1:0]       frameCnt_q, frameCnt_d;
  logic                  blinkPhase_q, blinkPhase_d;
  logic                  frameTick_q, frameTick_d;
  logic [6:0]            segOut_q, segOut_d;
  logic                  dpOut_q, dpOut_d;
  logic [NUM_DIGITS-1:0] anOut_q, anOut_d;

  logic                  slotEnd;
  logic                  lastIdx;
  logic [NUM_DIGITS-1:0] lzMask;
  logic                  upperZero;
  logic [3:0]            curCode;
  logic [6:0]            curGlyph;
  logic                  curBlank;
  logic [31:0]           onCyc;

  assign curCode = digits[{idx_q, 2'b00} +: 4];

  seg7_decode #(
    .HEX_MODE (HEX_MODE != 0)
  ) u_decode (
    .code_i  (curCode),
    .glyph_o (curGlyph)
  );

  // Digit i is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lzMask    = '0;
    upperZero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upperZero = upperZero & (digits[4*i +: 4] == 4'h0);
      lzMask[i] = lz_en & upperZero;
    end
  end

  // Scan timing: prescaler, digit index, frame counter and blink phase advance together.
  always_comb begin
    slotEnd      = (presc_q == PRE_W'(SCAN_DIV - 1));
    lastIdx      = (idx_q == IDX_W'(NUM_DIGITS - 1));
    presc_d      = slotEnd ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    frameCnt_d   = frameCnt_q;
    blinkPhase_d = blinkPhase_q;
    frameTick_d  = slotEnd & lastIdx;
    if (slotEnd) begin
      idx_d = lastIdx ? '0 : idx_q + 1'b1;
    end
    if (slotEnd && lastIdx) begin
      if (frameCnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frameCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        frameCnt_d = frameCnt_q + 1'b1;
      end
    end
  end

  // Next display outputs for the current slot: glyph or blank, dp, and PWM-gated anode.
  always_comb begin
    curBlank = lzMask[idx_q] | (blinkPhase_q & blink_mask[idx_q]);
    onCyc    = (&brightness) ? 32'(SCAN_DIV)
                             : ((32'(brightness) * 32'(SCAN_DIV)) >> BRIGHT_W);
    segOut_d = curBlank ? SEG_BLANK : curGlyph;
    dpOut_d  = curBlank ? 1'b1 : ~dp_in[idx_q];
    anOut_d  = '1;
    if (32'(presc_q) < onCyc) begin
      anOut_d[idx_q] = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q      <= '0;
      idx_q        <= '0;
      frameCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
      frameTick_q  <= 1'b0;
      segOut_q     <= SEG_BLANK;
      dpOut_q      <= 1'b1;
      anOut_q      <= '1;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      frameCnt_q   <= frameCnt_d;
      blinkPhase_q <= blinkPhase_d;
      frameTick_q  <= frameTick_d;
      segOut_q     <= segOut_d;
      dpOut_q      <= dpOut_d;
      anOut_q      <= anOut_d;
    end
  end

  assign seg_n      = segOut_q;
  assign dp_n       = dpOut_q;
  assign an_n       = anOut_q;
  assign frame_tick = frameTick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: a decimal-mode and a hex-mode instance share
// the same inputs; expected outputs come from a time-based reference model.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 16;
  localparam int BW = 3;
  localparam int BF = 2;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [6:0] seg;
    logic [6:0] segHex;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } expT;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [15:0]   digits = 16'h0;
  logic [3:0]    dp_in = 4'h0;
  logic [3:0]    blink_mask = 4'h0;
  logic          lz_en = 1'b0;
  logic [BW-1:0] brightness = '1;

  logic [6:0] seg_n, segH_n;
  logic       dp_n, dpH_n;
  logic [3:0] an_n, anH_n;
  logic       frame_tick, tickH;

  // Staged input values, copied onto the DUT pins at the next falling edge.
  logic [15:0]   nDigits = 16'h0;
  logic [3:0]    nDp = 4'h0;
  logic [3:0]    nBlink = 4'h0;
  logic          nLz = 1'b0;
  logic [BW-1:0] nBright = '1;

  expT expQ[$];
  expT monE;
  int  vectors = 0;
  int  miscompares = 0;
  int  failPrints = 0;
  int  tModel = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW), .BLINK_FRAMES(BF), .HEX_MODE(0)
  ) dut (
    .CLK(CLK), .RESET(RESET), .digits(digits), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_en(lz_en), .brightness(brightness),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .frame_tick(frame_tick)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BRIGHT_W(BW), .BLINK_FRAMES(BF), .HEX_MODE(1)
  ) dutHex (
    .CLK(CLK), .RESET(RESET), .digits(digits), .dp_in(dp_in),
    .blink_mask(blink_mask), .lz_en(lz_en), .brightness(brightness),
    .seg_n(segH_n), .dp_n(dpH_n), .an_n(anH_n), .frame_tick(tickH)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] refGlyph(input logic [3:0] code, input bit hex);
    if (!hex && code > 4'd9) return 7'h3F;
    return GLYPH[code];
  endfunction

  // Expected outputs t cycles after reset release, derived from elapsed time alone.
  function automatic expT modelOut(input int t, input logic [15:0] d, input logic [3:0] dp,
                                   input logic [3:0] bm, input logic lz, input logic [BW-1:0] br);
    expT  e;
    int   p, idx, frame, onCyc;
    bit   phase, blank;
    logic [3:0] code;
    p     = t % SD;
    idx   = (t / SD) % ND;
    frame = t / (SD * ND);
    phase = ((frame / BF) % 2) == 1;
    code  = 4'((d >> (4 * idx)) & 16'hF);
    blank = (idx > 0 && lz && (d >> (4 * idx)) == 16'h0) || (phase && bm[idx]);
    onCyc = (br == '1) ? SD : ((int'(br) * SD) >> BW);
    e.seg    = blank ? 7'h7F : refGlyph(code, 0);
    e.segHex = blank ? 7'h7F : refGlyph(code, 1);
    e.dp     = blank ? 1'b1 : ~dp[idx];
    e.an     = 4'hF;
    if (p < onCyc) e.an[idx] = 1'b0;
    e.tick   = (t % (SD * ND)) == (SD * ND - 1);
    return e;
  endfunction

  // Drive n cycles with the staged inputs and queue the response expected for each.
  task automatic applyStimulus(input logic rst, input int n);
    expT e;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      RESET      = rst;
      digits     = nDigits;
      dp_in      = nDp;
      blink_mask = nBlink;
      lz_en      = nLz;
      brightness = nBright;
      if (rst) begin
        e = '{seg: 7'h7F, segHex: 7'h7F, dp: 1'b1, an: 4'hF, tick: 1'b0};
        tModel = 0;
      end else begin
        e = modelOut(tModel, nDigits, nDp, nBlink, nLz, nBright);
        tModel++;
      end
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (failPrints < 40) begin
        failPrints++;
        $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  function automatic logic [15:0] biasedDigits();
    logic [15:0] d;
    for (int i = 0; i < ND; i++) begin
      d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return d;
  endfunction

  // Monitor: every cycle the DUTs present a display state, compare it with the oldest expectation.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() > 0) begin
        monE = expQ.pop_front();
        checkOutput("seg_n",      32'(seg_n),      32'(monE.seg));
        checkOutput("dp_n",       32'(dp_n),       32'(monE.dp));
        checkOutput("an_n",       32'(an_n),       32'(monE.an));
        checkOutput("frame_tick", 32'(frame_tick), 32'(monE.tick));
        checkOutput("hex_seg_n",  32'(segH_n),     32'(monE.segHex));
        checkOutput("hex_dp_n",   32'(dpH_n),      32'(monE.dp));
        checkOutput("hex_an_n",   32'(anH_n),      32'(monE.an));
        checkOutput("hex_tick",   32'(tickH),      32'(monE.tick));
        checkOutput("an_onehot",  32'($countones(~an_n) <= 1), 32'd1);
      end
    end
  end

  // Directed scenarios followed by a long randomized run.
  initial begin
    $display("[TB] seg7_scan_ctrl bench start");
    nDigits = 16'h3210;
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 300);

    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 2 * SD + 7);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 100);

    nDigits = 16'h321B;
    applyStimulus(1'b0, 64);

    nDigits = 16'h0050; nLz = 1'b1;
    applyStimulus(1'b0, 64);
    nDigits = 16'h0000; nDp = 4'b1000;
    applyStimulus(1'b0, 64);

    nDigits = 16'h1234; nLz = 1'b0; nDp = 4'b0101; nBlink = 4'b0011;
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 8 * SD * ND);

    nBright = 3'b100;
    applyStimulus(1'b0, 64);
    nBright = 3'b000;
    applyStimulus(1'b0, 64);
    nBright = 3'b111;
    applyStimulus(1'b0, 64);

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        nDigits = biasedDigits();
        nDp     = 4'($urandom_range(0, 15));
        nBlink  = 4'($urandom_range(0, 15));
        nLz     = 1'($urandom_range(0, 1));
        nBright = BW'($urandom_range(0, 7));
      end
      applyStimulus($urandom_range(0, 699) == 0, 1);
    end

    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge CLK);
    @(posedge CLK);
    #2;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
